seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a row of DIGITS common-anode/cathode seven-segment digits; next generation of the team's single-digit hex decoder.
- Captures a packed hex word plus decimal points into a shadow register on a load strobe, then scans one digit per refresh tick with registered segment/anode outputs.
- Sits between the stopwatch/counter datapath and board pins.

Parameters:
- DIGITS, 8, number of digits scanned (1..16).
- CLK_DIV, 50000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the output.
- AN_ACTIVE_LOW, 0, 1 inverts an at the output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low freezes scan and blanks the display.
- load  in  1  single-cycle strobe; capture data/dp_in into shadow.
- data  in  4*DIGITS  packed nibbles; digit i = data[4i+3:4i], digit 0 rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- seg  out  7  {a,b,c,d,e,f,g}, a = bit 6.
- dp  out  1  decimal point of the active digit.
- an  out  DIGITS  one-hot digit select.
- slot_tick  out  1  one-cycle pulse at each digit advance.

Behaviour:
- Reset (async): prescaler cnt=0, idx=0, shadow nibbles/dp=0, seg/dp/an all inactive (polarity applied), slot_tick=0.
- Decode (active-high, before polarity): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=0000001 (dash, g only).
- Prescaler: while en=1, cnt counts 0..CLK_DIV-1. At cnt==CLK_DIV-1: cnt<=0, idx<=idx+1, and slot_tick=1 for that cycle. idx wraps DIGITS-1 -> 0.
- Outputs are registered. Every cycle: an<=onehot(idx), seg<=decode(shadow[idx]), dp<=shadow_dp[idx], all one cycle behind idx.
- Latency: a new idx appears on an/seg the cycle after the advancing edge.
- Load: at a clk edge with load=1, shadow<=data and shadow_dp<=dp_in, independent of en and of the scan phase.
  - If the loaded digit is active, seg reflects the new value 1 cycle after the capture edge.
  - Load concurrent with a tick: both take effect; the new idx displays the new shadow value.
- en=0: cnt and idx hold, an/seg/dp driven inactive from the next edge, slot_tick=0. Re-asserting en resumes from the held cnt/idx; output is valid 1 cycle later.
- load and en are sampled only at clk edges; no internal handshake beyond the strobe.
- Reset mid-scan returns immediately to the reset values; shadow contents are lost.
- Widths: cnt is $clog2(CLK_DIV) bits; idx is $clog2(DIGITS) bits (min 1). For DIGITS not a power of two, idx wraps explicitly at DIGITS-1.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: at each load, a DIGITS-bit blank mask is computed from data and registered with the shadow.
  - Digit i (i>0) is blanked if nibbles i..DIGITS-1 are all 0. Digit 0 is never blanked.
  - A blanked digit drives seg inactive, but its an and dp behave normally.
  - The mask resets to 0.
- Undefined: no mask logic; every digit displays its decoded nibble, including leading zeros.

Decomposition:
- Package seg7_pkg: 7-bit segment constants for 0..F, a decode function, and a localparam for SEG_OFF=7'b0000000.
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit segments using the package function.
- The scan driver instantiates one decoder on the muxed nibble.

Test Plan:
- DIGITS=4, CLK_DIV=4, rst held then released, en=1, no load -> an walks 0001,0010,0100,1000,0001; each slot lasts 4 cycles; seg=1111110 throughout; slot_tick every 4th cycle.
- load with data=16'h1A3F, dp_in=4'b0100 -> across one full scan, seg shows 0000001, 1111001, 1110111, 0110000 for digits 0..3; dp=1 only when an=0100.
- Load during an active slot of digit 0 changing 0->8 -> seg becomes 1111111 exactly 1 cycle after the capture edge, an unchanged.
- en dropped for 10 cycles mid-slot -> an/seg inactive from the next edge; on re-enable the same digit resumes and the remaining slot length is preserved.
- rst asserted asynchronously between edges during a scan -> outputs inactive immediately, idx=0; SEG_ACTIVE_LOW=1 gives seg=7'h7F.
- With SEG7_LEADING_ZERO_BLANK_EN, data=16'h0050 -> digits 3 and 2 are blank, digit 1 shows 1011011, digit 0 shows 1111110; with data=16'h0000 only digit 0 is lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings and the hex-to-segment decode function shared
// by the seven-segment display blocks. Segment order is {a,b,c,d,e,f,g},
// a = bit 6, all active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF   = 7'b0000000;

    localparam logic [6:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [6:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [6:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [6:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b0011111;
    localparam logic [6:0] SEG_HEX_C = 7'b1001110;
    localparam logic [6:0] SEG_HEX_D = 7'b0111101;
    localparam logic [6:0] SEG_HEX_E = 7'b1001111;
    // F is shown as a dash (g only) rather than the letter.
    localparam logic [6:0] SEG_HEX_F = 7'b0000001;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = SEG_HEX_0;
            4'h1:    hex_to_seg = SEG_HEX_1;
            4'h2:    hex_to_seg = SEG_HEX_2;
            4'h3:    hex_to_seg = SEG_HEX_3;
            4'h4:    hex_to_seg = SEG_HEX_4;
            4'h5:    hex_to_seg = SEG_HEX_5;
            4'h6:    hex_to_seg = SEG_HEX_6;
            4'h7:    hex_to_seg = SEG_HEX_7;
            4'h8:    hex_to_seg = SEG_HEX_8;
            4'h9:    hex_to_seg = SEG_HEX_9;
            4'hA:    hex_to_seg = SEG_HEX_A;
            4'hB:    hex_to_seg = SEG_HEX_B;
            4'hC:    hex_to_seg = SEG_HEX_C;
            4'hD:    hex_to_seg = SEG_HEX_D;
            4'hE:    hex_to_seg = SEG_HEX_E;
            default: hex_to_seg = SEG_HEX_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-high seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a row of seven-segment digits.
// A load strobe captures the packed hex word and decimal points into a shadow
// register; a prescaler advances the active digit once per CLK_DIV cycles and
// the segment/anode outputs are registered one cycle behind the digit index.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  slot_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   shadow_dp;
    logic                tick;
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic [6:0]          seg_dec;
    logic [6:0]          seg_p1;
    logic                dp_p1;
    logic [DIGITS-1:0]   an_p1;

    function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
        return DIGITS'(1) << i;
    endfunction

    assign tick      = en && (cnt_p0 == CNT_LAST);
    assign slot_tick = tick;

    // Stage p0: prescaler and digit index; both freeze while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else if (tick) begin
            cnt_p0 <= '0;
            idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
        end else if (en) begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // Shadow capture on the load strobe, independent of scan phase and en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else if (load) begin
            shadow    <= data;
            shadow_dp <= dp_in;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_mask;
    logic [DIGITS-1:0] blank_next;
    logic              seen_nz;

    // Digit i>0 is blank while it and every digit above it are zero
    always_comb begin
        blank_next = '0;
        seen_nz    = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen_nz       = seen_nz | (data[4*i +: 4] != 4'h0);
            blank_next[i] = ~seen_nz;
        end
    end

    // Blank mask travels with the shadow word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_mask <= '0;
        end else if (load) begin
            blank_mask <= blank_next;
        end
    end
`endif

    // Pick the nibble, decimal point and blank flag of the active digit
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_p0 == IDX_W'(i)) begin
                nib_sel = shadow[4*i +: 4];
                dp_sel  = shadow_dp[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                blank_sel = blank_mask[i];
`endif
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble (nib_sel),
        .segs   (seg_dec)
    );

    // Stage p1: registered pin outputs with polarity applied, blank when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p1 <= SEG_INV;
            dp_p1  <= DP_INV;
            an_p1  <= AN_INV;
        end else if (en) begin
            seg_p1 <= (blank_sel ? SEG_OFF : seg_dec) ^ SEG_INV;
            dp_p1  <= dp_sel ^ DP_INV;
            an_p1  <= onehot(idx_p0) ^ AN_INV;
        end else begin
            seg_p1 <= SEG_OFF ^ SEG_INV;
            dp_p1  <= DP_INV;
            an_p1  <= AN_INV;
        end
    end

    assign seg = seg_p1;
    assign dp  = dp_p1;
    assign an  = an_p1;

endmodule
